osc_bank: RTL
=============

Name: osc_bank

Overview:
Bank of OSC_VOICES programmable square-wave tone oscillators. It produces the per-voice active vector that is bit-counted to form the PWM on-count.
Each voice has a half-period divider advanced by a shared sample-rate tick. A note-on/off write port with a valid/ready handshake sets each voice's half-period and enable.
The block sits directly upstream of the bitcount/pwm pair: its oscs_o output feeds the bitcount word input.

Parameters:
OSC_VOICES, 7, number of oscillator voices (≥1)
DIV_BW, 16, width of the per-voice half-period value and counter
VOICE_BW, $clog2(OSC_VOICES) (minimum 1), width of the voice index (derived localparam, not overridable)

Ports:
clk_i  input  1  system clock, all logic on rising edge
rst_i  input  1  synchronous reset, active-high
tick_i  input  1  oscillator advance strobe; one-cycle pulse per sample period
wrValid_i  input  1  write request valid
wrReady_o  output  1  write request ready
wrVoice_i  input  VOICE_BW  target voice index
wrHalfPeriod_i  input  DIV_BW  half-period in ticks
wrEnable_i  input  1  1 = note-on/retune, 0 = note-off
oscs_o  output  OSC_VOICES  registered square-wave output per voice; 0 when the voice is disabled

Behaviour:
- One clock domain. Synchronous active-high reset. No combinational path from any input to oscs_o.
- Per-voice state: halfPeriod[v] (DIV_BW), en[v], cnt[v] (DIV_BW), phase[v]. oscs_o[v] = phase[v], which is a register.
- Reset (rst_i=1 at an edge):
  - All halfPeriod, en, cnt and phase cleared; oscs_o=0.
  - FSM goes to IDLE; capture registers cleared.
  - wrReady_o=0 while rst_i=1.
- Write FSM, 2 states:
  - IDLE: wrReady_o=1 (when rst_i=0). On wrValid_i&wrReady_o, capture voice, halfPeriod and enable, then go to COMMIT.
  - COMMIT: wrReady_o=0. Apply the captured write at the next edge, then return to IDLE.
  - Maximum throughput is one write per 2 cycles.
  - wrValid_i may be held high. The next request is accepted in the following IDLE cycle.
- Commit rules for voice v = captured index:
  - index ≥ OSC_VOICES: write discarded, no state change; the handshake still completes normally.
  - enable=1 and halfPeriod≠0: halfPeriod[v] updated, en[v]=1, cnt[v]=0, phase[v]=1. The output goes high at the commit edge (immediate note onset, phase restart also on retune).
  - enable=0, or halfPeriod=0: en[v]=0, cnt[v]=0, phase[v]=0. halfPeriod[v] still updated.
- Tick rules, applied at an edge with tick_i=1 to every enabled voice not being committed that edge:
  - If cnt[v]==halfPeriod[v]-1: cnt[v]=0 and phase[v] toggles.
  - Otherwise cnt[v] increments.
  - Disabled voices hold cnt=0 and phase=0.
  - tick_i=0: all counters and phases hold.
- Timing:
  - Output period is 2*halfPeriod ticks, 50% duty.
  - halfPeriod=1 toggles on every tick.
  - The counter never exceeds halfPeriod-1 and never wraps past DIV_BW.
- Simultaneous events:
  - Commit and tick at the same edge on the same voice: commit wins and the tick is ignored for that voice only.
  - Other voices tick normally.
- Reset mid-operation: a pending COMMIT is discarded and the captured write is lost.
- Latency:
  - Request accepted at edge k; state and oscs_o updated at edge k+1.
  - wrReady_o high again after edge k+1.

Test Plan:
1. Reset: hold rst_i 3 cycles with wrValid_i=1 -> oscs_o=0 and wrReady_o=0 throughout, no write accepted. First cycle after release: wrReady_o=1.
2. Write voice 2, half=3, en=1, tick_i=1 every cycle -> oscs_o=7'b0000100 one edge after acceptance. Then 3 cycles high, 3 low, period 6 cycles, repeating; other bits stay 0.
3. Hold wrValid_i high for two writes (voice 0 half=2, voice 1 half=5) -> wrReady_o toggles 1,0,1,0. Voice 1 goes high exactly 2 cycles after voice 0.
4. Out-of-range and degenerate writes (OSC_VOICES=7): write voice 7 -> handshake completes and oscs_o unchanged. Write voice 3 half=0 en=1 -> oscs_o[3] stays 0. Note-off to active voice 2 -> oscs_o[2]=0 at the commit edge.
5. Tick gating and collision, with tick_i pulsing every 4th cycle:
   - Voice 4 half=2 -> toggles only on tick edges, so its period is 16 cycles.
   - A commit edge coincides with a tick on voice 4 -> phase=1, cnt=0, tick ignored for voice 4.
6. Reset during COMMIT: assert rst_i in the COMMIT cycle of a note-on to voice 5 -> oscs_o[5] remains 0 after reset, and FSM in IDLE with wrReady_o=1.

Source files
------------

// File: rtl/osc_bank.sv
// Bank of square-wave tone oscillators advanced by a shared sample tick.
// Voices are programmed through a two-state capture/commit write port.
module osc_bank #(
  parameter int OSC_VOICES = 7,
  parameter int DIV_BW     = 16,
  localparam int VOICE_BW  = (OSC_VOICES > 1) ? $clog2(OSC_VOICES) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tick_i,
  input  logic                  wrValid_i,
  output logic                  wrReady_o,
  input  logic [VOICE_BW-1:0]   wrVoice_i,
  input  logic [DIV_BW-1:0]     wrHalfPeriod_i,
  input  logic                  wrEnable_i,
  output logic [OSC_VOICES-1:0] oscs_o
);

  typedef enum logic {S_IDLE, S_COMMIT} state_t;

  state_t                state_q;
  logic                  ready_q;
  logic [VOICE_BW-1:0]   cap_voice_q;
  logic [DIV_BW-1:0]     cap_half_q;
  logic                  cap_en_q;

  logic [DIV_BW-1:0]     half_q [OSC_VOICES];
  logic [DIV_BW-1:0]     half_d [OSC_VOICES];
  logic [DIV_BW-1:0]     cnt_q  [OSC_VOICES];
  logic [DIV_BW-1:0]     cnt_d  [OSC_VOICES];
  logic [OSC_VOICES-1:0] en_q, en_d;
  logic [OSC_VOICES-1:0] phase_q, phase_d;

  logic accept;

  // ready_q tracks IDLE; gating with rst_i keeps the port closed while reset is held
  assign wrReady_o = ready_q & ~rst_i;
  assign accept    = wrValid_i & wrReady_o;
  assign oscs_o    = phase_q;

  always_comb begin
    half_d  = half_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    phase_d = phase_q;
    for (int unsigned v = 0; v < OSC_VOICES; v++) begin
      // A commit to this voice overrides any tick arriving on the same edge
      if (state_q == S_COMMIT && cap_voice_q == VOICE_BW'(v)) begin
        half_d[v] = cap_half_q;
        cnt_d[v]  = '0;
        if (cap_en_q && cap_half_q != '0) begin
          en_d[v]    = 1'b1;
          phase_d[v] = 1'b1;
        end else begin
          en_d[v]    = 1'b0;
          phase_d[v] = 1'b0;
        end
      end else if (tick_i && en_q[v]) begin
        if (cnt_q[v] == half_q[v] - DIV_BW'(1)) begin
          cnt_d[v]   = '0;
          phase_d[v] = ~phase_q[v];
        end else begin
          cnt_d[v] = cnt_q[v] + DIV_BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      cap_voice_q <= '0;
      cap_half_q  <= '0;
      cap_en_q    <= 1'b0;
      en_q        <= '0;
      phase_q     <= '0;
      for (int unsigned v = 0; v < OSC_VOICES; v++) begin
        half_q[v] <= '0;
        cnt_q[v]  <= '0;
      end
    end else begin
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      phase_q <= phase_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cap_voice_q <= wrVoice_i;
            cap_half_q  <= wrHalfPeriod_i;
            cap_en_q    <= wrEnable_i;
            state_q     <= S_COMMIT;
            ready_q     <= 1'b0;
          end
        end
        S_COMMIT: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
